tick_arbiter: RTL

- Round-robin scheduler that shares one 8-bit tick counter between N_REQ requesters.
- Each requester presents a tick count. The block grants the counter to one requester at a time, counts 0..ticks, and then returns a one-cycle done pulse to that requester.
- Sits in front of the counter datapath and owns its sequencing: load, run, complete, release.

---
 rtl/tick_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tick_arbiter.sv
// Round-robin owner of a shared tick counter: grant, count 0..target, pulse done, release.
// A withdrawn request aborts the run; the pointer always advances past the last owner.
module tick_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] ticks_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   abort_o
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_nx;
  logic [PW-1:0]                 rr_ptr, rr_nx, owner, owner_nx, sel, idx;
  logic                          sel_vld;
  logic [CNT_W-1:0]              target, target_nx, count_nx;
  logic [N_REQ-1:0]              grant_nx, done_nx;
  logic                          abort_nx;
  logic [N_REQ-1:0][CNT_W-1:0]   ticks_a;

  assign ticks_a = ticks_i;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(N_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  // Walk downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (req_i[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rr_nx     = rr_ptr;
    owner_nx  = owner;
    target_nx = target;
    count_nx  = count_o;
    grant_nx  = grant_o;
    done_nx   = '0;
    abort_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_nx      = '0;
          grant_nx[sel] = 1'b1;
          owner_nx      = sel;
          target_nx     = ticks_a[sel];
          count_nx      = '0;
          state_nx      = RUN;
        end
      end
      RUN: begin
        // Withdrawal outranks completion on the same edge.
        if (!req_i[owner]) begin
          state_nx = IDLE;
          grant_nx = '0;
          count_nx = '0;
          abort_nx = 1'b1;
          rr_nx    = inc_ptr(owner);
        end else if (count_o == target) begin
          state_nx       = DONE;
          done_nx[owner] = 1'b1;
          count_nx       = '0;
        end else begin
          count_nx = count_o + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        grant_nx = '0;
        rr_nx    = inc_ptr(owner);
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      target  <= '0;
      count_o <= '0;
      grant_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= '0;
      abort_o <= 1'b0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_nx;
      owner   <= owner_nx;
      target  <= target_nx;
      count_o <= count_nx;
      grant_o <= grant_nx;
      busy_o  <= |grant_nx;
      done_o  <= done_nx;
      abort_o <= abort_nx;
    end
  end
endmodule
